// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-SRC control path: opcodes, ALU codes,
// sequencer states and opcode classification helpers.
package cpu_pkg;

  // Opcodes as found in ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes (register ALU ops use their own opcode directly)
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RST,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT,
    ST_PAUSE
  } seq_state_t;

  // add .. shl: two-register ALU instructions
  function automatic logic is_alu_reg(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  // addi / andi / ori
  function automatic logic is_alu_imm(input logic [4:0] op);
    return (op >= OP_ADDI) && (op <= OP_ORI);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for mini-SRC: fetch (F0..F2), then execute
// steps T3..T7 dispatched on the opcode, with memory wait, halt and pause.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int STEP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ir,
  input  logic              con,
  input  logic              mem_ready,
  input  logic              stop,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              Read,
  output logic              Write,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Cout,
  output logic              CONin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              BAout,
  output logic [OP_W-1:0]   alu_op,
  output logic              run,
  output logic [STEP_W-1:0] tstep
);

  seq_state_t state_reg;
  seq_state_t state_next;
  seq_state_t boundary_next;

  logic [4:0] opcode;
  logic       ir_unused;

  assign opcode    = ir[31:27];
  assign ir_unused = ^ir[26:0];

  // Where to go after the last step of an instruction
  assign boundary_next = stop ? ST_PAUSE : ST_F0;

  // State register; reset takes effect immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_RST;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_RST:   state_next = ST_F0;
      ST_F0:    state_next = ST_F1;
      ST_F1:    if (mem_ready) state_next = ST_F2;
      ST_F2:    state_next = ST_T3;
      ST_T3: begin
        if (opcode == OP_HALT)
          state_next = ST_HALT;
        else if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST ||
                 opcode == OP_BR || is_alu_reg(opcode) || is_alu_imm(opcode))
          state_next = ST_T4;
        else
          state_next = boundary_next;
      end
      ST_T4:    state_next = ST_T5;
      ST_T5: begin
        if (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR)
          state_next = ST_T6;
        else
          state_next = boundary_next;
      end
      ST_T6: begin
        if (opcode == OP_LD) begin
          if (mem_ready) state_next = ST_T7;
        end else if (opcode == OP_ST) begin
          state_next = ST_T7;
        end else begin
          state_next = boundary_next;
        end
      end
      ST_T7: begin
        // st waits for the write to complete; ld's read already finished
        if (opcode != OP_ST || mem_ready) state_next = boundary_next;
      end
      ST_HALT:  state_next = ST_HALT;
      ST_PAUSE: if (!stop) state_next = ST_F0;
      default:  state_next = ST_RST;
    endcase
  end

  // Output decode of the current state (and the instruction it is executing)
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = '0;
    run    = 1'b1;
    tstep  = '0;
    unique case (state_reg)
      ST_F0: begin
        tstep = STEP_W'(0);
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      ST_F1: begin
        tstep = STEP_W'(1);
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_F2: begin
        tstep = STEP_W'(2);
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        tstep = STEP_W'(3);
        if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu_reg(opcode) || is_alu_imm(opcode)) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (opcode == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (opcode == OP_JR) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end
      end
      ST_T4: begin
        tstep = STEP_W'(4);
        if (is_alu_reg(opcode)) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          alu_op = OP_W'(opcode);
        end else if (opcode == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          Cout = 1'b1; Zin = 1'b1;
          if (opcode == OP_ANDI)     alu_op = OP_W'(ALU_AND);
          else if (opcode == OP_ORI) alu_op = OP_W'(ALU_OR);
          else                       alu_op = OP_W'(ALU_ADD);
        end
      end
      ST_T5: begin
        tstep = STEP_W'(5);
        if (opcode == OP_LD || opcode == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (opcode == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_W'(ALU_ADD);
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      ST_T6: begin
        tstep = STEP_W'(6);
        if (opcode == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (con) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      ST_T7: begin
        tstep = STEP_W'(7);
        if (opcode == OP_ST) begin
          MDRout = 1'b1; Write = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      default: run = 1'b0;  // RST, HALT, PAUSE
    endcase
  end

endmodule
